memory_access_unit: RTL and testbench

Memory-stage controller of the pipelined ARM32 core. It sits directly upstream of the load-writeback stage. It registers the instruction leaving execute and drives the data-memory request/ready handshake for loads and stores. It stalls the pipeline while an access is outstanding and hands the instruction, its branch tag and any loaded word to the writeback stage.

---
 rtl/memory_access_unit_pkg.sv | 37 +++
 rtl/memory_access_unit_if.sv | 27 ++
 rtl/memory_access_unit_fsm.sv | 56 +++++
 rtl/memory_access_unit.sv | 104 ++++++++++
 tb/tb_memory_access_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_unit_pkg.sv
// rtl/memory_access_unit_pkg.sv - shared opcode decode, NOP encoding and memory-stage state types
package cpu_pkg;

    localparam logic [2:0]  LOAD_OP_HI   = 3'b110;
    localparam logic [3:0]  LOAD_OP_LO   = 4'b1000;
    localparam logic [2:0]  STORE_OP_HI  = 3'b111;
    localparam logic [3:0]  STORE_OP_LO  = 4'b1001;
    localparam logic [31:0] NOP_ENC      = 32'h0000_0000;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_state_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_LOAD,
        ACC_STORE
    } access_t;

    // The 7-bit opcode is taken from the instruction's class/op field, bits [27:21].
    function automatic logic [6:0] decode_opcode(input logic [31:0] instr);
        return instr[27:21];
    endfunction

    function automatic access_t classify_access(input logic [6:0] opcode);
        access_t kind;
        kind = ACC_NONE;
        if (opcode[6:4] == LOAD_OP_HI || opcode[6:3] == LOAD_OP_LO) begin
            kind = ACC_LOAD;
        end else if (opcode[6:4] == STORE_OP_HI || opcode[6:3] == STORE_OP_LO) begin
            kind = ACC_STORE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// rtl/memory_access_unit_if.sv - data-memory request/ready bus between the memory stage and data memory
interface memory_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/memory_access_unit_fsm.sv
// rtl/memory_access_unit_fsm.sv - access state register, mem_ready completion and load word capture
module mem_access_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cur_is_load,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data
);

    mem_state_t  state_q, state_d;
    logic [31:0] load_data_q, load_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    done = 1'b1;
                    if (cur_is_load) begin
                        load_data_d = mem_rdata;
                    end
                    // A new access captured on the completing edge continues without an idle gap.
                    state_d = start ? ACCESS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == ACCESS);
    assign load_data = load_data_q;

endmodule

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - memory stage: captures execute output, runs loads/stores, retires to writeback
module memory_access_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr_in,
    input  logic                 branch_ref,
    input  logic                 branch_in,
    input  logic                 sel_stall,
    input  logic [31:0]          addr_in,
    input  logic [31:0]          wdata_in,
    memory_access_unit_if.master mem,
    output logic [31:0]          load_data,
    output logic                 stall_out,
    output logic                 branch_value,
    output logic [31:0]          instr_output
);

    logic [31:0] instr_q, instr_d;
    logic        branch_q, branch_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    access_t     kind_q, kind_d;
    logic [31:0] wb_instr_q, wb_instr_d;
    logic        wb_branch_q, wb_branch_d;

    logic        busy;
    logic        done;
    logic        live;
    logic        advance;
    logic        start;
    access_t     in_kind;

    mem_access_fsm u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cur_is_load (kind_q == ACC_LOAD),
        .mem_ready   (mem.mem_ready),
        .mem_rdata   (mem.mem_rdata),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= NOP_INSTR;
            branch_q    <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            kind_q      <= ACC_NONE;
            wb_instr_q  <= NOP_INSTR;
            wb_branch_q <= 1'b0;
        end else begin
            instr_q     <= instr_d;
            branch_q    <= branch_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            kind_q      <= kind_d;
            wb_instr_q  <= wb_instr_d;
            wb_branch_q <= wb_branch_d;
        end
    end

    always_comb begin
        live     = (branch_in == branch_ref);
        in_kind  = classify_access(decode_opcode(instr_in));
        advance  = (!busy && !sel_stall) || done;
        start    = advance && live && (in_kind != ACC_NONE);

        instr_d     = instr_q;
        branch_d    = branch_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        kind_d      = kind_q;
        // Writeback sees a bubble on every edge where nothing leaves the stage.
        wb_instr_d  = NOP_INSTR;
        wb_branch_d = wb_branch_q;

        if (advance) begin
            instr_d     = instr_in;
            branch_d    = branch_in;
            addr_d      = addr_in;
            wdata_d     = wdata_in;
            kind_d      = live ? in_kind : ACC_NONE;
            wb_instr_d  = instr_q;
            wb_branch_d = branch_q;
        end
    end

    assign mem.mem_req   = busy;
    assign mem.mem_we    = busy && (kind_q == ACC_STORE);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign stall_out     = busy;
    assign branch_value  = wb_branch_q;
    assign instr_output  = wb_instr_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - directed self-checking bench for memory_access_unit
module tb_memory_access_unit;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] LD_A = 32'h0C00_0011;
    localparam logic [31:0] LD_B = 32'h0800_0022;
    localparam logic [31:0] ST_A = 32'h0E00_0033;
    localparam logic [31:0] LD_S = 32'h0C00_0044;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_in;
    logic        branch_ref;
    logic        branch_in;
    logic        sel_stall;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [31:0] load_data;
    logic        stall_out;
    logic        branch_value;
    logic [31:0] instr_output;

    int n_cmp;
    int n_bad;

    memory_access_unit_if mem_bus ();

    memory_access_unit #(.NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_in     (instr_in),
        .branch_ref   (branch_ref),
        .branch_in    (branch_in),
        .sel_stall    (sel_stall),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .mem          (mem_bus.master),
        .load_data    (load_data),
        .stall_out    (stall_out),
        .branch_value (branch_value),
        .instr_output (instr_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic br, input logic [31:0] a, input logic [31:0] d);
        instr_in  = ins;
        branch_in = br;
        addr_in   = a;
        wdata_in  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(NOP, 1'b0, 32'h0, 32'h0);
        branch_ref = 1'b0;
        sel_stall  = 1'b0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        step();
        step();
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", mem_bus.mem_req); end
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall_out); end
        n_cmp++; if (instr_output !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h expected %h", instr_output, NOP); end
        n_cmp++; if (load_data !== 32'h0) begin n_bad++; $display("FAIL reset_load_data: got %h expected 0", load_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_access();
        drive(LD_A, 1'b0, 32'h0000_0500, 32'h0);
        step();
        drive(NOP, 1'b0, 32'h0, 32'h0);
        n_cmp++; if (mem_bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_req: got %b expected 1", mem_bus.mem_req); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_req: got %b expected 0", mem_bus.mem_req); end
        n_cmp++; if (mem_bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL midrst_we: got %b expected 0", mem_bus.mem_we); end
        n_cmp++; if (mem_bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_addr: got %h expected 0", mem_bus.mem_addr); end
        n_cmp++; if (mem_bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL midrst_wdata: got %h expected 0", mem_bus.mem_wdata); end
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %b expected 0", stall_out); end
        n_cmp++; if (branch_value !== 1'b0) begin n_bad++; $display("FAIL midrst_branch: got %b expected 0", branch_value); end
        n_cmp++; if (instr_output !== NOP) begin n_bad++; $display("FAIL midrst_instr: got %h expected %h", instr_output, NOP); end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_no_retry: cycle %0d got %b expected 0", c, mem_bus.mem_req); end
        end
    endtask

    task automatic test_load_wait();
        int req_cnt;
        int stall_cnt;
        int seen;
        int bad_addr;
        req_cnt = 0; stall_cnt = 0; seen = 0; bad_addr = 0;
        drive(LD_A, 1'b0, 32'h0000_0100, 32'h0);
        step();
        drive(NOP, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 8; c++) begin
            if (mem_bus.mem_req === 1'b1) begin
                req_cnt++;
                if (mem_bus.mem_addr !== 32'h0000_0100 || mem_bus.mem_we !== 1'b0) bad_addr++;
            end
            if (stall_out === 1'b1) stall_cnt++;
            if (instr_output === LD_A) seen++;
            if (mem_bus.mem_req === 1'b1 && req_cnt == 3) begin
                mem_bus.mem_ready = 1'b1;
                mem_bus.mem_rdata = 32'hDEAD_BEEF;
            end else begin
                mem_bus.mem_ready = 1'b0;
                mem_bus.mem_rdata = 32'h0BAD_0BAD;
            end
            step();
            if (c == 2) begin
                n_cmp++; if (instr_output !== LD_A) begin n_bad++; $display("FAIL load_out_after_done: got %h expected %h", instr_output, LD_A); end
                n_cmp++; if (load_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_data_with_out: got %h expected deadbeef", load_data); end
            end
        end
        mem_bus.mem_ready = 1'b0;
        n_cmp++; if (req_cnt != 3) begin n_bad++; $display("FAIL load_req_cycles: got %0d expected 3", req_cnt); end
        n_cmp++; if (stall_cnt != 3) begin n_bad++; $display("FAIL load_stall_cycles: got %0d expected 3", stall_cnt); end
        n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL load_out_count: got %0d expected 1", seen); end
        n_cmp++; if (bad_addr != 0) begin n_bad++; $display("FAIL load_bus_stable: got %0d unstable cycles expected 0", bad_addr); end
        n_cmp++; if (load_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_data: got %h expected deadbeef", load_data); end
    endtask

    task automatic test_store();
        int we_cnt;
        int stall_cnt;
        int seen;
        int bad_data;
        we_cnt = 0; stall_cnt = 0; seen = 0; bad_data = 0;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h5555_AAAA;
        drive(ST_A, 1'b0, 32'h0000_0200, 32'h1234_5678);
        step();
        drive(NOP, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            if (mem_bus.mem_we === 1'b1) begin
                we_cnt++;
                if (mem_bus.mem_wdata !== 32'h1234_5678 || mem_bus.mem_addr !== 32'h0000_0200) bad_data++;
            end
            if (stall_out === 1'b1) stall_cnt++;
            if (instr_output === ST_A) seen++;
            step();
        end
        mem_bus.mem_ready = 1'b0;
        n_cmp++; if (we_cnt != 1) begin n_bad++; $display("FAIL store_we_cycles: got %0d expected 1", we_cnt); end
        n_cmp++; if (stall_cnt != 1) begin n_bad++; $display("FAIL store_stall_cycles: got %0d expected 1", stall_cnt); end
        n_cmp++; if (bad_data != 0) begin n_bad++; $display("FAIL store_bus: got %0d bad cycles expected 0", bad_data); end
        n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL store_out_count: got %0d expected 1", seen); end
        n_cmp++; if (load_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL store_load_data_kept: got %h expected deadbeef", load_data); end
    endtask

    task automatic test_squashed();
        int req_cnt;
        req_cnt = 0;
        mem_bus.mem_ready = 1'b1;
        drive(LD_S, 1'b1, 32'h0000_0600, 32'h0);
        step();
        drive(NOP, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 4; c++) begin
            if (mem_bus.mem_req === 1'b1) req_cnt++;
            if (c == 0) begin
                n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL squash_stall: got %b expected 0", stall_out); end
            end
            step();
            if (c == 0) begin
                n_cmp++; if (instr_output !== LD_S) begin n_bad++; $display("FAIL squash_out: got %h expected %h", instr_output, LD_S); end
                n_cmp++; if (branch_value !== 1'b1) begin n_bad++; $display("FAIL squash_tag: got %b expected 1", branch_value); end
            end
        end
        mem_bus.mem_ready = 1'b0;
        n_cmp++; if (req_cnt != 0) begin n_bad++; $display("FAIL squash_req: got %0d expected 0", req_cnt); end
        n_cmp++; if (load_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL squash_load_data: got %h expected deadbeef", load_data); end
    endtask

    task automatic test_back_to_back();
        mem_bus.mem_ready = 1'b1;
        drive(LD_A, 1'b0, 32'h0000_0300, 32'h0);
        step();
        drive(LD_B, 1'b0, 32'h0000_0304, 32'h0);
        mem_bus.mem_rdata = 32'hAAAA_0001;
        n_cmp++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_0300) begin n_bad++; $display("FAIL b2b_first_req: got req=%b addr=%h expected req=1 addr=00000300", mem_bus.mem_req, mem_bus.mem_addr); end
        step();
        drive(NOP, 1'b0, 32'h0, 32'h0);
        mem_bus.mem_rdata = 32'hBBBB_0002;
        n_cmp++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_0304) begin n_bad++; $display("FAIL b2b_second_req: got req=%b addr=%h expected req=1 addr=00000304", mem_bus.mem_req, mem_bus.mem_addr); end
        n_cmp++; if (instr_output !== LD_A) begin n_bad++; $display("FAIL b2b_first_out: got %h expected %h", instr_output, LD_A); end
        n_cmp++; if (load_data !== 32'hAAAA_0001) begin n_bad++; $display("FAIL b2b_first_word: got %h expected aaaa0001", load_data); end
        step();
        mem_bus.mem_ready = 1'b0;
        n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL b2b_req_done: got %b expected 0", mem_bus.mem_req); end
        n_cmp++; if (instr_output !== LD_B) begin n_bad++; $display("FAIL b2b_second_out: got %h expected %h", instr_output, LD_B); end
        n_cmp++; if (load_data !== 32'hBBBB_0002) begin n_bad++; $display("FAIL b2b_second_word: got %h expected bbbb0002", load_data); end
        step();
    endtask

    task automatic test_sel_stall();
        sel_stall = 1'b1;
        mem_bus.mem_ready = 1'b0;
        drive(LD_A, 1'b0, 32'h0000_0400, 32'h0);
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL hold_req: cycle %0d got %b expected 0", c, mem_bus.mem_req); end
        end
        sel_stall = 1'b0;
        step();
        drive(NOP, 1'b0, 32'h0, 32'h0);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hCAFE_F00D;
        n_cmp++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_0400) begin n_bad++; $display("FAIL hold_access: got req=%b addr=%h expected req=1 addr=00000400", mem_bus.mem_req, mem_bus.mem_addr); end
        step();
        mem_bus.mem_ready = 1'b0;
        n_cmp++; if (instr_output !== LD_A) begin n_bad++; $display("FAIL hold_out: got %h expected %h", instr_output, LD_A); end
        n_cmp++; if (load_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL hold_word: got %h expected cafef00d", load_data); end
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL hold_stall_end: got %b expected 0", stall_out); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_reset_mid_access();
        test_load_wait();
        test_store();
        test_squashed();
        test_back_to_back();
        test_sel_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
